// File: rtl/timer_slave_pkg.sv
// ============================================================================
// Package     : timer_slave_pkg
// Description : Shared definitions for the memory-mapped down-counting timer:
//               register indices, CTRL/STATUS bit positions, FSM state
//               encoding and a helper that assembles the CTRL read word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_slave_pkg;

  // Register indices, decoded from addr[3:2]
  localparam logic [1:0] c_REG_CTRL   = 2'd0;
  localparam logic [1:0] c_REG_LOAD   = 2'd1;
  localparam logic [1:0] c_REG_COUNT  = 2'd2;
  localparam logic [1:0] c_REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int c_CTRL_EN_BIT     = 0;
  localparam int c_CTRL_AUTO_BIT   = 1;
  localparam int c_CTRL_IRQ_EN_BIT = 2;
  localparam int c_CTRL_PRESC_LSB  = 8;

  // Widest PRESC field that still fits in the 32-bit CTRL word
  localparam int c_PRESC_MAX_W = 32 - c_CTRL_PRESC_LSB;

  // STATUS bit positions
  localparam int c_STATUS_EXP_BIT = 0;

  // Timer FSM encoding
  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Assemble the CTRL read value; PRESC arrives zero-extended to the widest
  // field so the function stays independent of the module parameter.
  function automatic logic [31:0] f_pack_ctrl(
    input logic                     i_en,
    input logic                     i_auto,
    input logic                     i_irq_en,
    input logic [c_PRESC_MAX_W-1:0] i_presc
  );
    logic [31:0] w_word;
    w_word                                     = '0;
    w_word[c_CTRL_EN_BIT]                      = i_en;
    w_word[c_CTRL_AUTO_BIT]                    = i_auto;
    w_word[c_CTRL_IRQ_EN_BIT]                  = i_irq_en;
    w_word[c_CTRL_PRESC_LSB +: c_PRESC_MAX_W]  = i_presc;
    return w_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_slave_prescaler.sv
// ============================================================================
// Module      : timer_prescaler
// Description : Prescaler for the timer. Counts cycles while running and
//               emits a one-cycle tick whenever the phase counter equals
//               PRESC, giving one tick every PRESC+1 running cycles.
// Ports       : CLK      - clock, rising edge
//               RST      - asynchronous reset, active low
//               i_run    - timer is running; counter advances
//               i_clear  - restart the phase counter at 0 (timer start)
//               i_presc  - prescale divider value
//               o_tick   - one-cycle tick pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_presc,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_pc;
  logic                  w_match;

  assign w_match = (r_pc == i_presc);
  assign o_tick  = i_run & w_match;

  // If PRESC is lowered below the current phase while running, the counter
  // simply wraps around before matching again.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pc <= '0;
    end else if (i_clear) begin
      r_pc <= '0;
    end else if (i_run) begin
      r_pc <= w_match ? '0 : r_pc + PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_slave.sv
// ============================================================================
// Module      : timer_slave
// Description : Memory-mapped 32-bit down-counting timer on the peripheral
//               bus. Decodes register reads/writes, runs a prescaled
//               down-counter with optional auto-reload, and raises a level
//               interrupt on expiry. Reads return one cycle later through a
//               registered response.
// Ports       : CLK          - clock, rising edge
//               RST          - asynchronous reset, active low
//               timer_enable - slave select, one access per cycle
//               MemWrite     - 1 = write, 0 = read (qualified by select)
//               addr         - byte offset, [3:2] selects the register
//               WriteData    - write data
//               rdata        - registered read data (held between reads)
//               rvalid       - one-cycle read response strobe
//               irq          - level interrupt, EXP & IRQ_EN, from a flop
// Params      : PRESCALE_W   - prescaler width, 1 .. 24
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_slave
  import timer_slave_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        timer_enable,
  input  logic        MemWrite,
  input  logic [3:0]  addr,
  input  logic [31:0] WriteData,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_auto;
  logic                  r_irq_en;
  logic [PRESCALE_W-1:0] r_presc;
  logic [31:0]           r_load;
  logic [31:0]           r_count;
  logic                  r_exp;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic       w_wr;
  logic       w_rd;
  logic [1:0] w_sel;
  logic       w_ctrl_wr;
  logic       w_load_wr;
  logic       w_count_wr;
  logic       w_status_wr;
  logic       w_unused;

  assign w_wr        = timer_enable & MemWrite;
  assign w_rd        = timer_enable & ~MemWrite;
  assign w_sel       = addr[3:2];
  assign w_ctrl_wr   = w_wr & (w_sel == c_REG_CTRL);
  assign w_load_wr   = w_wr & (w_sel == c_REG_LOAD);
  assign w_count_wr  = w_wr & (w_sel == c_REG_COUNT);
  assign w_status_wr = w_wr & (w_sel == c_REG_STATUS);

  // Byte lanes within a register are not decoded
  assign w_unused = ^addr[1:0];

  // --------------------------------------------------------------------------
  // Run control and prescaler
  // --------------------------------------------------------------------------
  logic w_running;
  logic w_start;
  logic w_stop_req;
  logic w_tick;
  logic w_tick_eff;
  logic w_count_zero;
  logic w_expire;

  assign w_running  = (r_state == ST_RUNNING);
  assign w_start    = ~w_running & w_ctrl_wr & WriteData[c_CTRL_EN_BIT];
  assign w_stop_req = w_ctrl_wr & ~WriteData[c_CTRL_EN_BIT];

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .CLK     (CLK),
    .RST     (RST),
    .i_run   (w_running),
    .i_clear (w_start),
    .i_presc (r_presc),
    .o_tick  (w_tick)
  );

  // A software stop in the same cycle as a tick swallows the tick, so it can
  // neither decrement nor expire the counter.
  assign w_tick_eff   = w_tick & ~w_stop_req;
  assign w_count_zero = (r_count == 32'd0);
  assign w_expire     = w_tick_eff & w_count_zero;

  // --------------------------------------------------------------------------
  // FSM: EN is not stored separately; it is the RUNNING state itself, which
  // keeps CTRL.EN and the FSM consistent by construction.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_STOPPED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_ctrl_wr) begin
      // Software write has priority over a simultaneous one-shot expiry
      w_state_nxt = WriteData[c_CTRL_EN_BIT] ? ST_RUNNING : ST_STOPPED;
    end else if (w_expire && !r_auto) begin
      w_state_nxt = ST_STOPPED;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_auto   <= 1'b0;
      r_irq_en <= 1'b0;
      r_presc  <= '0;
      r_load   <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_auto   <= WriteData[c_CTRL_AUTO_BIT];
        r_irq_en <= WriteData[c_CTRL_IRQ_EN_BIT];
        r_presc  <= WriteData[c_CTRL_PRESC_LSB +: PRESCALE_W];
      end
      if (w_load_wr) begin
        r_load <= WriteData;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counter, expiry flag and interrupt
  // --------------------------------------------------------------------------
  logic [31:0] w_count_nxt;
  logic        w_exp_nxt;
  logic        w_irq_en_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (w_count_wr) begin
      // Direct write beats a coincident tick
      w_count_nxt = WriteData;
    end else if (w_tick_eff) begin
      if (w_count_zero) begin
        w_count_nxt = r_auto ? r_load : 32'd0;
      end else begin
        w_count_nxt = r_count - 32'd1;
      end
    end
  end

  always_comb begin
    w_exp_nxt = r_exp;
    if (w_expire) begin
      // Setting beats a simultaneous write-1-to-clear
      w_exp_nxt = 1'b1;
    end else if (w_status_wr && WriteData[c_STATUS_EXP_BIT]) begin
      w_exp_nxt = 1'b0;
    end
  end

  assign w_irq_en_nxt = w_ctrl_wr ? WriteData[c_CTRL_IRQ_EN_BIT] : r_irq_en;

  // irq is registered from the next-state of EXP and IRQ_EN so it rises on
  // the same edge as EXP while never combinationally following the bus.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
      r_exp   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_exp   <= w_exp_nxt;
      irq     <= w_exp_nxt & w_irq_en_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read response: captures the pre-edge register view
  // --------------------------------------------------------------------------
  logic [31:0] w_rd_val;

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      c_REG_CTRL:   w_rd_val = f_pack_ctrl(w_running, r_auto, r_irq_en,
                                           c_PRESC_MAX_W'(r_presc));
      c_REG_LOAD:   w_rd_val = r_load;
      c_REG_COUNT:  w_rd_val = r_count;
      c_REG_STATUS: w_rd_val[c_STATUS_EXP_BIT] = r_exp;
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= w_rd;
      if (w_rd) begin
        rdata <= w_rd_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_slave.sv
// ============================================================================
// Module      : tb_timer_slave
// Description : Self-checking bench for timer_slave: a table of bus vectors,
//               hand-written multi-cycle corner sequences, and randomized
//               traffic compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_timer_slave;

  localparam int PW = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        timer_enable = 1'b0;
  logic        MemWrite = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  timer_slave #(
    .PRESCALE_W (PW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .timer_enable (timer_enable),
    .MemWrite     (MemWrite),
    .addr         (addr),
    .WriteData    (WriteData),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .irq          (irq)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: register contents tracked as plain integers, updated
  // once per clock from the rules of the register map.
  // --------------------------------------------------------------------------
  bit          m_run, m_auto, m_irqen, m_exp, m_rvalid, m_irq;
  int unsigned m_presc, m_load, m_count, m_pc;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_run = 0; m_auto = 0; m_irqen = 0; m_exp = 0; m_rvalid = 0; m_irq = 0;
    m_presc = 0; m_load = 0; m_count = 0; m_pc = 0; m_rdata = '0;
  endtask

  function automatic logic [31:0] model_read(input int sel);
    case (sel)
      0:       return (m_presc << 8) | (32'(m_irqen) << 2) | (32'(m_auto) << 1) | 32'(m_run);
      1:       return m_load;
      2:       return m_count;
      default: return 32'(m_exp);
    endcase
  endfunction

  task automatic model_step(input bit en, input bit we, input logic [3:0] a, input logic [31:0] d);
    int sel;
    bit wr, rd, tick, ctrl_w, halt, tick_ok, expire;
    sel     = int'(a[3:2]);
    wr      = en && we;
    rd      = en && !we;
    tick    = m_run && (m_pc == m_presc);
    ctrl_w  = wr && sel == 0;
    halt    = ctrl_w && !d[0];
    tick_ok = tick && !halt;
    expire  = tick_ok && (m_count == 0);
    if (rd) m_rdata = model_read(sel);
    m_rvalid = rd;
    if (ctrl_w && d[0] && !m_run) m_pc = 0;
    else if (m_run) m_pc = tick ? 0 : (m_pc + 1) % (1 << PW);
    if (wr && sel == 2) m_count = d;
    else if (tick_ok) m_count = (m_count == 0) ? (m_auto ? m_load : 0) : m_count - 1;
    if (expire) m_exp = 1;
    else if (wr && sel == 3 && d[0]) m_exp = 0;
    if (ctrl_w) m_run = d[0];
    else if (expire && !m_auto) m_run = 0;
    if (ctrl_w) begin
      m_auto  = d[1];
      m_irqen = d[2];
      m_presc = (d >> 8) & ((1 << PW) - 1);
    end
    if (wr && sel == 1) m_load = d;
    m_irq = m_exp && m_irqen;
  endtask

  // --------------------------------------------------------------------------
  // Bus driver: one access per call; returns 1 ns after the edge that ends it
  // --------------------------------------------------------------------------
  task automatic cycle(input bit en, input bit we, input logic [3:0] a, input logic [31:0] d);
    timer_enable = en;
    MemWrite     = we;
    addr         = a;
    WriteData    = d;
    @(posedge CLK);
    model_step(en, we, a, d);
    #1;
    timer_enable = 1'b0;
    MemWrite     = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d); cycle(1, 1, a, d); endtask
  task automatic rd(input logic [3:0] a);                       cycle(1, 0, a, 32'h0); endtask
  task automatic idle();                                        cycle(0, 0, 4'h0, 32'h0); endtask

  typedef struct {
    bit          en;
    bit          we;
    logic [3:0]  a;
    logic [31:0] d;
    bit          x_rvalid;
    logic [31:0] x_rdata;
    bit          x_irq;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] auto_seq[5];
  int          rsel;
  int          rop;
  logic [3:0]  ra;
  logic [31:0] rdat;

  initial begin
    // Readback table from the reset state
    tbl[0]  = '{1, 1, 4'h4, 32'hDEAD_BEEF, 0, 32'h0,         0};
    tbl[1]  = '{1, 1, 4'h8, 32'h1234_5678, 0, 32'h0,         0};
    tbl[2]  = '{1, 1, 4'h0, 32'hFFFF_FFF6, 0, 32'h0,         0};
    tbl[3]  = '{1, 0, 4'h1, 32'h0,         1, 32'h0000_FF06, 0};
    tbl[4]  = '{1, 0, 4'hE, 32'h0,         1, 32'h0,         0};
    tbl[5]  = '{1, 0, 4'h6, 32'h0,         1, 32'hDEAD_BEEF, 0};
    tbl[6]  = '{1, 0, 4'h8, 32'h0,         1, 32'h1234_5678, 0};
    tbl[7]  = '{1, 1, 4'h0, 32'h0000_0307, 0, 32'h1234_5678, 0};
    tbl[8]  = '{1, 0, 4'h0, 32'h0,         1, 32'h0000_0307, 0};
    tbl[9]  = '{1, 1, 4'h0, 32'h0,         0, 32'h0000_0307, 0};
    tbl[10] = '{1, 0, 4'h8, 32'h0,         1, 32'h1234_5678, 0};
    tbl[11] = '{0, 0, 4'h0, 32'h0,         0, 32'h1234_5678, 0};
    auto_seq = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd2};

    // Reset state
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset rdata", rdata, 32'h0);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    RST = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(tbl[i].x_rvalid));
      chk($sformatf("vec%0d rdata", i), rdata, tbl[i].x_rdata);
      chk($sformatf("vec%0d irq", i), 32'(irq), 32'(tbl[i].x_irq));
    end

    // One-shot: COUNT=3, PRESC=1 -> expiry 8 edges after the CTRL write
    wr(4'h4, 32'd3);
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h0000_0105);
    for (int k = 1; k <= 8; k++) begin
      idle();
      chk($sformatf("oneshot irq k=%0d", k), 32'(irq), (k == 8) ? 32'h1 : 32'h0);
    end
    rd(4'h0); chk("oneshot CTRL EN cleared", rdata, 32'h0000_0104);
    rd(4'h8); chk("oneshot COUNT", rdata, 32'h0);
    rd(4'hC); chk("oneshot EXP", rdata, 32'h1);

    // STATUS: writing 0 has no effect, writing 1 clears
    wr(4'hC, 32'h0); chk("status w0 irq", 32'(irq), 32'h1);
    wr(4'hC, 32'h1); chk("status w1c irq", 32'(irq), 32'h0);
    rd(4'hC);        chk("status after clear", rdata, 32'h0);

    // Auto-reload: LOAD=2, COUNT=0, PRESC=0
    wr(4'h4, 32'd2);
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h0000_0003);
    for (int k = 0; k < 5; k++) begin
      rd(4'h8);
      chk($sformatf("auto COUNT[%0d]", k), rdata, auto_seq[k]);
      chk($sformatf("auto rvalid[%0d]", k), 32'(rvalid), 32'h1);
    end
    rd(4'hC); chk("auto EXP", rdata, 32'h1);
    chk("auto irq masked", 32'(irq), 32'h0);
    wr(4'h0, 32'h0);
    wr(4'hC, 32'h1);

    // Clear on the expiry edge: set wins
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h0000_0007); chk("setwins pre irq", 32'(irq), 32'h0);
    wr(4'hC, 32'h1);         chk("setwins irq", 32'(irq), 32'h1);
    rd(4'hC);                chk("setwins EXP", rdata, 32'h1);

    // Asynchronous reset while running with a read response outstanding
    rd(4'h0);
    chk("prerst rvalid", 32'(rvalid), 32'h1);
    chk("prerst rdata", rdata, 32'h0000_0007);
    chk("prerst irq", 32'(irq), 32'h1);
    #2 RST = 1'b0;
    #1;
    chk("asyncrst rvalid", 32'(rvalid), 32'h0);
    chk("asyncrst rdata", rdata, 32'h0);
    chk("asyncrst irq", 32'(irq), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    rd(4'h0); chk("postrst CTRL", rdata, 32'h0);
    rd(4'h4); chk("postrst LOAD", rdata, 32'h0);
    rd(4'h8); chk("postrst COUNT", rdata, 32'h0);
    rd(4'hC); chk("postrst STATUS", rdata, 32'h0);

    // COUNT write on a tick wins; CTRL EN=0 on a tick swallows it
    wr(4'h8, 32'd5);
    wr(4'h0, 32'h0000_0001);
    wr(4'h8, 32'h10);
    wr(4'h0, 32'h0);
    rd(4'h8); chk("collision COUNT", rdata, 32'h10);

    // CTRL EN=0 on the expiry tick: no expiry
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h0000_0005);
    wr(4'h0, 32'h0000_0004); chk("stop-on-expiry irq", 32'(irq), 32'h0);
    rd(4'hC);                chk("stop-on-expiry EXP", rdata, 32'h0);
    rd(4'h0);                chk("stop-on-expiry CTRL", rdata, 32'h0000_0004);
    rd(4'h8);                chk("stop-on-expiry COUNT", rdata, 32'h0);

    // Randomized traffic against the reference model
    RST = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rop  = $urandom_range(0, 9);
      ra   = 4'($urandom_range(0, 15));
      rsel = int'(ra[3:2]);
      case (rsel)
        0:       rdat = ($urandom & 32'hFFFF_00F8) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 7);
        1, 2:    rdat = $urandom_range(0, 6);
        default: rdat = $urandom;
      endcase
      if (rop < 4)      idle();
      else if (rop < 7) rd(ra);
      else              wr(ra, rdat);
      chk($sformatf("rnd%0d rvalid", n), 32'(rvalid), 32'(m_rvalid));
      chk($sformatf("rnd%0d rdata", n), rdata, m_rdata);
      chk($sformatf("rnd%0d irq", n), 32'(irq), 32'(m_irq));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_slave.md
# timer_slave

Memory-mapped 32-bit down-counting timer that responds on the SoC peripheral bus, on the slave end of the memory stage's `timer_enable`, `MemWrite`, address and write-data lines. It decodes register reads and writes, runs a prescaled down-counter and raises a level interrupt on expiry. Read data returns with a one-cycle registered response for the writeback-side read mux.

## Interface
- `PRESCALE_W`, default 8: width of the prescaler field and counter.
- `CLK`, input, 1: clock; all state is updated on the rising edge.
- `RST`, input, 1: reset, asynchronous, active-low.
- `timer_enable`, input, 1: slave select, one bus access per cycle while high.
- `MemWrite`, input, 1: 1 = write, 0 = read; qualified by `timer_enable`.
- `addr`, input, 4: byte offset; `[3:2]` selects the register; `[1:0]` is ignored.
- `WriteData`, input, 32: write data.
- `rdata`, output, 32: registered read data.
- `rvalid`, output, 1: high for one cycle when `rdata` holds a read response.
- `irq`, output, 1: interrupt, level-sensitive, active-high.

## Operation
- Register map, selected by `addr[3:2]`:
  - 0 CTRL (RW): bit0 EN; bit1 AUTO; bit2 IRQ_EN; bits[8+PRESCALE_W-1:8] PRESC. All other bits read 0.
  - 1 LOAD (RW): 32-bit reload value.
  - 2 COUNT (RW): the current count. A write loads COUNT directly.
  - 3 STATUS: bit0 EXP. Reads return EXP. Writing 1 to bit0 clears EXP; writing 0 has no effect.
- Access rules:
  - A write occurs when `timer_enable & MemWrite`.
  - A read occurs when `timer_enable & ~MemWrite`.
- FSM has two states, STOPPED and RUNNING:
  - STOPPED goes to RUNNING when a CTRL write sets EN=1. The prescaler counter `pc` clears to 0 on this transition.
  - RUNNING goes to STOPPED when a CTRL write sets EN=0, or on expiry with AUTO=0. EN is hardware-cleared in the expiry case.
  - The FSM state and CTRL.EN are always consistent.
- Prescaler and tick:
  - In RUNNING, `pc` increments each cycle.
  - When `pc == PRESC`, a tick is generated and `pc` returns to 0. A tick therefore occurs every PRESC+1 cycles; PRESC=0 gives a tick every cycle.
- On a tick:
  - If COUNT != 0, COUNT decrements by 1.
  - If COUNT == 0, the timer expires: EXP is set. With AUTO=1, COUNT reloads from LOAD. With AUTO=0, COUNT stays at 0 and the FSM moves to STOPPED.
- `irq = EXP & IRQ_EN`, driven only from flops, with no combinational path from the bus inputs.
- Simultaneous events:
  - Expiry and a STATUS write-1-clear in the same cycle: EXP stays set (set wins).
  - A COUNT write and a tick in the same cycle: the written value wins. `pc` is not reset by a COUNT write.
  - A CTRL write with EN=0 and a tick in the same cycle: the write wins and no decrement or expiry occurs.
  - LOAD=0 with AUTO=1: the timer expires on every tick.
- Reset:
  - All registers, `pc` and the FSM clear asynchronously; the FSM goes to STOPPED.
  - Any in-flight read response is dropped; `rvalid` goes low immediately.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `irq`=0, CTRL=0, LOAD=0, COUNT=0, EXP=0, `pc`=0.
- Write latency: a write in cycle N takes effect at the edge ending cycle N and is visible to a read issued in cycle N+1.
- Read latency: a read issued in cycle N gives `rvalid`=1 and valid `rdata` in cycle N+1.
  - `rdata` captures register values as they stand in cycle N, before that edge's update.
  - `rdata` holds its last value while `rvalid`=0.
- Back-to-back reads are supported: one response per cycle, with no stalls and no wait states.
- Expiry timing: with EN set at edge E, PRESC=p and COUNT=c, EXP rises at edge E + (c+1)(p+1). `irq` rises at the same edge when IRQ_EN=1.

## Structure
- A shared package holds:
  - The register index constants CTRL=0, LOAD=1, COUNT=2, STATUS=3.
  - CTRL bit positions for EN, AUTO, IRQ_EN and the PRESC low bit.
  - The FSM state encoding STOPPED/RUNNING.
- One sub-module, `timer_prescaler`: takes `PRESC` and run/clear inputs, and outputs a one-cycle `tick`. It contains `pc` and the `pc == PRESC` compare.
- The top level holds the register file, bus decode, count/expiry logic, FSM and read-response register.

## Test plan
- Reset: assert RST low mid-RUNNING, with a read in flight → all outputs 0, FSM STOPPED, `rvalid` low in the same cycle.
- One-shot: LOAD/COUNT=3, PRESC=1, CTRL=0x5 (EN, IRQ_EN) → EXP and `irq` rise 8 cycles after the CTRL write; EN then reads 0 and COUNT reads 0.
- Auto-reload: LOAD=2, COUNT=0, PRESC=0, CTRL=0x3 → expiry after 1 tick, then every 3 ticks; COUNT reads the sequence 2,1,0,2.
- STATUS: write 0x1 while EXP=1 → EXP clears and `irq` drops the next cycle. Repeat with the write timed on the expiry edge → EXP stays 1.
- Readback: write CTRL=0x0000_0307 and read it back → `rdata`=0x0000_0307 with `rvalid` one cycle later. Back-to-back reads of all 4 registers → 4 consecutive `rvalid` cycles.
- Collision: a COUNT write of 0x10 on a tick cycle → COUNT reads 0x10, not 0x0F. A CTRL write with EN=0 on the expiry tick → no EXP.
